// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard/stall controller.
//   - stall vector type and constants (bit order: [0] pc, [1] if_id,
//     [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved)
//   - multi-cycle down-counter type
//   - controller FSM state encodings
//   - saturating stall counter limit
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;
    typedef logic [5:0] mc_cnt_t;

    localparam stall_bus_t STALL_NONE    = 6'b000000;
    // Load-use hazard: freeze pc, if_id and insert a bubble at id_ex.
    localparam stall_bus_t STALL_LOADUSE = 6'b000111;
    // Multi-cycle execute: freeze everything up to and including ex_mem.
    localparam stall_bus_t STALL_MC      = 6'b001111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall / flush controller.
//   Turns decode load-use hazards, multi-cycle execute operations and
//   mem-stage flush requests into a per-stage hold vector, and keeps a
//   saturating count of stalled cycles.
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   id_stall_req  load-use hazard from decode
//   ex_mc_start   execute begins a multi-cycle op this cycle
//   ex_mc_cycles  total cycles N of that op (valid with ex_mc_start)
//   flush_req     pipeline flush request (dominates everything)
//   stall[5:0]    hold vector ([5] always 0)
//   flush         clear all pipeline registers this cycle
//   mc_done       multi-cycle result valid in execute this cycle
//   busy          FSM is in MC_BUSY
//   stall_cnt     saturating count of cycles with stall != 0
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_req,
    input  logic        ex_mc_start,
    input  logic [5:0]  ex_mc_cycles,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        mc_done,
    output logic        busy,
    output logic [31:0] stall_cnt
);

    state_t      state_q, state_d;
    mc_cnt_t     cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    stall_bus_t  stall_raw;
    logic        mc_done_raw;

    // Next-state and raw (pre-reset-gating) outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_raw   = STALL_NONE;
        mc_done_raw = 1'b0;

        if (flush_req) begin
            // Flush aborts any operation in flight and suppresses all stalls.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_mc_start && (ex_mc_cycles >= 6'd2)) begin
                        // Cycle T0 is already stalled here, so N-2 further
                        // stall cycles remain before the done cycle.
                        stall_raw = STALL_MC;
                        state_d   = ST_MC_BUSY;
                        cnt_d     = ex_mc_cycles - 6'd2;
                    end else begin
                        // A 0/1-cycle op completes immediately without stalling.
                        if (ex_mc_start) begin
                            mc_done_raw = 1'b1;
                        end
                        if (id_stall_req) begin
                            stall_raw = STALL_LOADUSE;
                        end
                    end
                end
                ST_MC_BUSY: begin
                    // ex_mc_start is ignored here; id_stall_req is subsumed
                    // by the wider multi-cycle vector.
                    if (cnt_q != '0) begin
                        stall_raw = STALL_MC;
                        cnt_d     = cnt_q - 6'd1;
                    end else begin
                        mc_done_raw = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are held at zero for as long as reset is asserted, including
    // the cycles before the first reset edge has cleared the flops.
    always_comb begin
        stall     = rst ? stall_raw                : STALL_NONE;
        flush     = rst ? flush_req                : 1'b0;
        mc_done   = rst ? mc_done_raw              : 1'b0;
        busy      = rst ? (state_q == ST_MC_BUSY)  : 1'b0;
        stall_cnt = rst ? stall_cnt_q              : 32'd0;
    end

    // Saturating stalled-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != STALL_NONE) && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stall_req;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        flush_req;
    logic [5:0]  stall;
    logic        flush;
    logic        mc_done;
    logic        busy;
    logic [31:0] stall_cnt;

    int checks;
    int errors;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_stall_req (id_stall_req),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .mc_done      (mc_done),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to the next falling edge, apply inputs, settle.
    task automatic cyc(input logic r, input logic ids, input logic st,
                       input logic [5:0] n, input logic fl);
        @(negedge clk);
        rst          = r;
        id_stall_req = ids;
        ex_mc_start  = st;
        ex_mc_cycles = n;
        flush_req    = fl;
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        id_stall_req = 1'b1;
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'h3F;
        flush_req    = 1'b1;

        // Reset held 3 cycles with every input high.
        cyc(1'b0, 1'b1, 1'b1, 6'h3F, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 6'h3F, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 6'h3F, 1'b1);
        chk("rst_stall",   {26'd0, stall}, 32'h00);
        chk("rst_flush",   {31'd0, flush}, 32'd0);
        chk("rst_mc_done", {31'd0, mc_done}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_cnt",     stall_cnt, 32'd0);

        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("idle_stall",  {26'd0, stall}, 32'h00);
        chk("idle_cnt",    stall_cnt, 32'd0);

        // N=5 multi-cycle op; a start at T2 must be ignored.
        cyc(1'b1, 1'b0, 1'b1, 6'd5, 1'b0);
        chk("n5_t0_stall", {26'd0, stall}, 32'h0F);
        chk("n5_t0_busy",  {31'd0, busy}, 32'd0);
        chk("n5_t0_done",  {31'd0, mc_done}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n5_t1_stall", {26'd0, stall}, 32'h0F);
        chk("n5_t1_busy",  {31'd0, busy}, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 6'd1, 1'b0);
        chk("n5_t2_ovl",   {26'd0, stall}, 32'h0F);
        chk("n5_t2_done",  {31'd0, mc_done}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n5_t3_stall", {26'd0, stall}, 32'h0F);
        chk("n5_t3_done",  {31'd0, mc_done}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n5_t4_stall", {26'd0, stall}, 32'h00);
        chk("n5_t4_done",  {31'd0, mc_done}, 32'd1);
        chk("n5_t4_busy",  {31'd0, busy}, 32'd1);
        chk("n5_t4_cnt",   stall_cnt, 32'd4);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n5_t5_busy",  {31'd0, busy}, 32'd0);
        chk("n5_t5_done",  {31'd0, mc_done}, 32'd0);
        chk("n5_t5_cnt",   stall_cnt, 32'd4);

        // N=1: done immediately, no stall.
        cyc(1'b1, 1'b0, 1'b1, 6'd1, 1'b0);
        chk("n1_done",     {31'd0, mc_done}, 32'd1);
        chk("n1_stall",    {26'd0, stall}, 32'h00);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n1_after",    {31'd0, busy | mc_done}, 32'd0);

        // N=2: stall at T0, done at T1.
        cyc(1'b1, 1'b0, 1'b1, 6'd2, 1'b0);
        chk("n2_t0_stall", {26'd0, stall}, 32'h0F);
        chk("n2_t0_done",  {31'd0, mc_done}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("n2_t1_stall", {26'd0, stall}, 32'h00);
        chk("n2_t1_done",  {31'd0, mc_done}, 32'd1);
        chk("n2_t1_cnt",   stall_cnt, 32'd5);

        // Load-use alone: one cycle only.
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        chk("lu_stall",    {26'd0, stall}, 32'h07);
        chk("lu_busy",     {31'd0, busy}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("lu_after",    {26'd0, stall}, 32'h00);
        chk("lu_cnt",      stall_cnt, 32'd6);

        // Flush abort: N=10 at T0, flush at T3.
        cyc(1'b1, 1'b0, 1'b1, 6'd10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 6'd3, 1'b1);
        chk("fl_t3_flush", {31'd0, flush}, 32'd1);
        chk("fl_t3_stall", {26'd0, stall}, 32'h00);
        chk("fl_t3_done",  {31'd0, mc_done}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("fl_t4_busy",  {31'd0, busy}, 32'd0);
        chk("fl_t4_flush", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
            chk("fl_no_done", {30'd0, busy, mc_done}, 32'd0);
        end
        chk("fl_cnt",      stall_cnt, 32'd9);

        // Reset mid-operation abandons the op.
        cyc(1'b1, 1'b0, 1'b1, 6'd10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 6'd4, 1'b0);
        chk("mrst_stall",  {26'd0, stall}, 32'h00);
        chk("mrst_busy",   {31'd0, busy}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
            chk("mrst_no_done", {30'd0, busy, mc_done}, 32'd0);
        end
        chk("mrst_cnt",    stall_cnt, 32'd0);

        // Saturation: preload counter, then 3 load-use stall cycles.
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        id_stall_req = 1'b1;
        #1;
        chk("sat_pre",     stall_cnt, 32'hFFFF_FFFD);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        chk("sat_1",       stall_cnt, 32'hFFFF_FFFE);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        chk("sat_2",       stall_cnt, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("sat_3",       stall_cnt, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("sat_hold",    stall_cnt, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
